// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage of the 32-bit MIPS core. Owns the fetch PC,
//                issues word reads to instruction memory under a credit
//                scheme, buffers returned words in a small FIFO and presents
//                them to decode over a valid/ready handshake. Branch/jump
//                redirects restart fetch and discard wrong-path returns.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   clock, all state on rising edge
//    reset           in   1   asynchronous, active-high
//    imem_req_valid  out  1   read request valid
//    imem_req_addr   out  32  byte address of request (word aligned)
//    imem_req_ready  in   1   memory accepts request this cycle
//    imem_rsp_valid  in   1   read data valid (in order, no backpressure)
//    imem_rsp_data   in   32  read data
//    instr_valid     out  1   instruction presented to decode
//    instruction     out  32  instruction word at FIFO head
//    instr_pc        out  32  byte address of that instruction
//    instr_ready     in   1   decode consumes head this cycle
//    redirect_valid  in   1   taken branch/jump: restart fetch
//    redirect_pc     in   32  new fetch address (low two bits ignored)
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]            fetch_pc;
    logic                   epoch;

    // In-flight queue: PC and epoch of every request accepted by memory
    // whose response has not yet returned.
    logic [31:0]            ifq_pc [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  ifq_epoch;
    logic [PTR_W-1:0]       ifq_wr;
    logic [PTR_W-1:0]       ifq_rd;
    logic [CNT_W-1:0]       ifq_count;

    // Instruction buffer presented to decode.
    logic [31:0]            buf_data [FIFO_DEPTH];
    logic [31:0]            buf_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]       buf_wr;
    logic [PTR_W-1:0]       buf_rd;
    logic [CNT_W-1:0]       buf_count;

    logic [CNT_W:0]         credit_used;
    logic                   req_fire;
    logic                   rsp_take;
    logic                   rsp_keep;
    logic                   pop_fire;
    logic                   unused_redirect_bits;

    // Every request holds a credit from issue until its word leaves the
    // buffer, so the buffer can always absorb every returning response.
    assign credit_used    = {1'b0, ifq_count} + {1'b0, buf_count};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing in flight (e.g. one issued before a reset)
    // has no owner and is ignored.
    assign rsp_take = imem_rsp_valid && (ifq_count != '0);
    // Stale-epoch words are dropped; a redirect this cycle also flushes.
    assign rsp_keep = rsp_take && (ifq_epoch[ifq_rd] == epoch) && !redirect_valid;
    assign pop_fire = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = (buf_count != '0);
    assign instruction = buf_data[buf_rd];
    assign instr_pc    = buf_pc[buf_rd];

    assign unused_redirect_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            epoch     <= 1'b0;
            ifq_epoch <= '0;
            ifq_wr    <= '0;
            ifq_rd    <= '0;
            ifq_count <= '0;
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ifq_pc[i]   <= '0;
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            // Fetch PC / in-flight push
            if (redirect_valid) begin
                fetch_pc  <= {redirect_pc[31:2], 2'b00};
                epoch     <= ~epoch;
                // Stamp every outstanding entry with the outgoing epoch so
                // that it mismatches the new one even after back-to-back
                // redirects flip the 1-bit epoch twice.
                ifq_epoch <= {FIFO_DEPTH{epoch}};
            end else if (req_fire) begin
                fetch_pc          <= fetch_pc + 32'd4;
                ifq_pc[ifq_wr]    <= fetch_pc;
                ifq_epoch[ifq_wr] <= epoch;
                ifq_wr            <= ifq_wr + PTR_W'(1);
            end

            // In-flight pop releases the credit whether or not the word is kept
            if (rsp_take) begin
                ifq_rd <= ifq_rd + PTR_W'(1);
            end
            ifq_count <= ifq_count + CNT_W'(req_fire) - CNT_W'(rsp_take);

            // Instruction buffer
            if (redirect_valid) begin
                buf_wr    <= '0;
                buf_rd    <= '0;
                buf_count <= '0;
            end else begin
                if (rsp_keep) begin
                    buf_data[buf_wr] <= imem_rsp_data;
                    buf_pc[buf_wr]   <= ifq_pc[ifq_rd];
                    buf_wr           <= buf_wr + PTR_W'(1);
                end
                if (pop_fire) begin
                    buf_rd <= buf_rd + PTR_W'(1);
                end
                buf_count <= buf_count + CNT_W'(rsp_keep) - CNT_W'(pop_fire);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed testbench for instr_fetch_unit with a behavioural
//                in-order instruction memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam int          D   = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int fails  = 0;

    // memory model controls (driven by the stimulus block only)
    int mem_lat  = 1;
    bit rand_mem = 1'b0;
    bit stray    = 1'b0;

    // memory model state (driven by the model only)
    int          cyc = 0;
    int          acc_count = 0;
    int          last_due = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // In-order memory: decides at the falling edge what it drives for the
    // next rising edge. A request seen valid&ready here is accepted there.
    always @(negedge clk) begin
        int due;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (reset) begin
            imem_req_ready = 1'b0;
            q_addr.delete();
            q_due.delete();
            last_due = 0;
        end else begin
            if (stray) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hBAD0_BAD0;
            end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(q_addr[0]);
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            imem_req_ready = rand_mem ? 1'($urandom_range(0, 1)) : 1'b1;
            if (imem_req_valid && imem_req_ready) begin
                due = cyc + (rand_mem ? int'($urandom_range(1, 4)) : mem_lat);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                q_addr.push_back(imem_req_addr);
                q_due.push_back(due);
                acc_count++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    // Consume n instructions and require pc = start, start+4, ... with
    // matching memory contents. Anything else reaching decode is a failure.
    task automatic stream_check(input string name, input logic [31:0] start, input int n,
                                input bit consecutive, input bit rand_rdy, input int max_cycles);
        logic [31:0] exp_pc;
        int got;
        int cycles;
        bit started;
        exp_pc  = start;
        got     = 0;
        cycles  = 0;
        started = 1'b0;
        while (got < n && cycles < max_cycles) begin
            tick();
            instr_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            sample();
            cycles++;
            if (instr_valid) begin
                started = 1'b1;
                if (instr_ready) begin
                    checks++;
                    if (instr_pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
                        fails++;
                        $display("FAIL %s[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h",
                                 name, got, instr_pc, instruction, exp_pc, mem_word(exp_pc));
                    end
                    exp_pc = exp_pc + 32'd4;
                    got++;
                end
            end else if (consecutive && started) begin
                checks++;
                fails++;
                $display("FAIL %s gap: got instr_valid=0 after %0d words, expected 1", name, got);
            end
        end
        if (got < n) begin
            checks++;
            fails++;
            $display("FAIL %s timeout: got %0d words, expected %0d", name, got, n);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s valids: got instr_valid=%b imem_req_valid=%b, expected 0 0",
                     name, instr_valid, imem_req_valid);
        end
        checks++;
        if (instruction !== 32'h0 || instr_pc !== 32'h0) begin
            fails++;
            $display("FAIL %s head: got instruction=%h instr_pc=%h, expected 0 0",
                     name, instruction, instr_pc);
        end
        checks++;
        if (imem_req_addr !== RPC) begin
            fails++;
            $display("FAIL %s addr: got %h, expected %h", name, imem_req_addr, RPC);
        end
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        tick();
        sample();
        check_reset_outputs("reset");
        do_reset();
    endtask

    task automatic test_stream();
        mem_lat = 1;
        do_reset();
        stream_check("stream", RPC, 6, 1'b1, 1'b0, 30);
    endtask

    task automatic test_backpressure();
        int a0;
        mem_lat = 1;
        do_reset();
        a0 = acc_count;
        repeat (10) tick();
        sample();
        checks++;
        if (acc_count - a0 != D) begin
            fails++;
            $display("FAIL bp_requests: got %0d, expected %0d", acc_count - a0, D);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_req_valid: got %b, expected 0", imem_req_valid);
        end
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== RPC || instruction !== mem_word(RPC)) begin
            fails++;
            $display("FAIL bp_head: got valid=%b pc=%h instr=%h, expected 1 %h %h",
                     instr_valid, instr_pc, instruction, RPC, mem_word(RPC));
        end
        stream_check("bp_resume", RPC, 8, 1'b0, 1'b0, 60);
    endtask

    task automatic test_redirect_inflight();
        mem_lat = 3;
        do_reset();
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        sample();
        checks++;
        if (q_addr.size() != 2) begin
            fails++;
            $display("FAIL redir_inflight: got %0d outstanding, expected 2", q_addr.size());
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_no_req: got imem_req_valid=%b, expected 0", imem_req_valid);
        end
        tick();
        redirect_valid = 1'b0;
        sample();
        checks++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_flush: got instr_valid=%b, expected 0", instr_valid);
        end
        stream_check("redir_0x100", 32'h0000_0100, 2, 1'b0, 1'b0, 40);
    endtask

    task automatic test_redirect_collision();
        mem_lat = 1;
        do_reset();
        instr_ready = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        sample();
        checks++;
        if ({instr_valid, imem_rsp_valid} !== 2'b11) begin
            fails++;
            $display("FAIL collide_setup: got valid/rsp=%b, expected 11",
                     {instr_valid, imem_rsp_valid});
        end
        tick();
        redirect_valid = 1'b0;
        sample();
        checks++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL collide_flush: got instr_valid=%b, expected 0", instr_valid);
        end
        stream_check("collide_0x200", 32'h0000_0200, 3, 1'b0, 1'b0, 40);
    endtask

    task automatic test_wrap_align();
        mem_lat = 2;
        do_reset();
        stream_check("wrap_pre", RPC, 2, 1'b0, 1'b0, 30);
        do_redirect(32'hFFFF_FFFC);
        stream_check("wrap", 32'hFFFF_FFFC, 2, 1'b0, 1'b0, 40);
        do_redirect(32'h0000_0103);
        stream_check("align", 32'h0000_0100, 2, 1'b0, 1'b0, 40);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        tick();
        redirect_pc    = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        stream_check("b2b_redirect", 32'h0000_0400, 3, 1'b0, 1'b0, 40);
    endtask

    task automatic test_async_reset();
        rand_mem = 1'b1;
        do_reset();
        stream_check("rand_pre", RPC, 10, 1'b0, 1'b1, 400);
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        tick();
        tick();
        reset       = 1'b0;
        stray       = 1'b1;
        instr_ready = 1'b1;
        sample();
        stray = 1'b0;
        stream_check("rand_post", RPC, 12, 1'b0, 1'b1, 400);
        rand_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_collision();
        test_wrap_align();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
